lsu_dmem_master: RTL and testbench
==================================

// Module: lsu_dmem_master
// PURPOSE
//  Load/store unit: the initiator side of the word-wide data-memory port.
//  Accepts one load/store request at a time from the core's MEM stage and drives memAddr/memWE/memWData.
//  Returns loads byte/half/word extracted and sign- or zero-extended.
//  Sub-word stores are built by read-modify-write, because the data memory writes whole words only.
// PARAMETERS
//  ADDR_W   32  request/memory address width (matches `ADDR_SIZE)
//  DATA_W   32  data word width (matches `WORD_LEN); fixed at 32, byte lanes = 4
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rstn        in   1       asynchronous, active-low reset
//  req         in   1       request strobe; sampled only in IDLE
//  isStore     in   1       1 = store, 0 = load
//  funct3      in   3       RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr        in   ADDR_W  byte address
//  storeData   in   DATA_W  store source (low bits used for B/H)
//  busy        out  1       high from the cycle after accept until done
//  done        out  1       one-cycle completion pulse
//  fault       out  1       valid with done: misaligned or illegal funct3
//  loadData    out  DATA_W  extended load result; valid with done, held until next accept
//  memAddr     out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
//  memWE       out  1       memory write enable
//  memWData    out  DATA_W  memory write word
//  memRData    in   DATA_W  memory read word (combinational on memAddr)
// BEHAVIOUR
//  - Reset (async, rstn=0): state IDLE; busy, done, fault, memWE = 0; memAddr, memWData, loadData = 0.
//    Mid-operation reset aborts immediately: memWE drops asynchronously and no partial write is issued afterwards.
//  - FSM states: IDLE, RD, WR, FIN.
//  - IDLE:
//    - req=1 latches isStore, funct3, addr, storeData.
//    - Legal aligned LW, LB, LH, LBU, LHU, SB, SH -> RD.
//    - Legal aligned SW -> WR.
//    - Fault -> FIN with fault=1.
//  - RD (1 cycle): memAddr driven; memRData captured.
//    - Load: extract lane at addr[1:0] (byte) or addr[1] (half); sign-extend for B/H, zero-extend for BU/HU.
//      Write the result to loadData; -> FIN.
//    - Sub-word store: merge storeData[7:0] or [15:0] into the captured word at its lane; -> WR.
//  - WR (1 cycle): memWE=1; memWData = full word (SW) or merged word (SB/SH); -> FIN.
//  - FIN: done=1 for exactly one cycle; busy=0; -> IDLE.
//  - Latency from accepting edge to done: load 2 cycles; SW 2; SB/SH 3; fault 1.
//  - Handshake: req is ignored while busy or in FIN; a new req is accepted no earlier than the cycle after done.
//  - memWE is high only in WR, for exactly one cycle per store; never high for loads or faults.
//  - memAddr holds its value from accept through FIN; it returns to 0 in IDLE.
//  - Illegal funct3 (load 011/110/111; store any value other than 000/001/010) -> fault=1, no memory access.
//  - Faults: loadData is not updated; memWE stays 0.
//  - Address wrap: memAddr is the truncated ADDR_W-bit value; no carry beyond ADDR_W.
// CONFIGURATION
//  - LSU_MISALIGN_TRAP_EN defined:
//    - H with addr[0]=1 or W with addr[1:0]!=0 -> fault=1, no access, done after 1 cycle.
//  - LSU_MISALIGN_TRAP_EN undefined:
//    - Offending low address bits are forced to 0: H uses addr[1] only; W uses the aligned word.
//    - The access proceeds normally with fault=0; illegal funct3 still faults.
// TESTING
//  - Preset mem[0x10]=0x80FF7F01; LB @0x12 -> done at +2 cycles, loadData=0xFFFFFFFF, memWE never high.
//  - Same word; LHU @0x12 -> 0x000080FF; LH @0x12 -> 0xFFFF80FF; LW @0x10 -> 0x80FF7F01.
//  - SB 0xAB @0x11 over word 0x11223344 -> one memWE pulse at +2, memWData=0x1122AB44, done at +3.
//  - SW 0xDEADBEEF @0x20 -> memWE at +1, memAddr=0x20, done at +2; req pulsed while busy is ignored.
//  - LW @0x22: with _EN -> fault=1 at +1, no write; without _EN -> word at 0x20 returned, fault=0.
//  - Drop rstn during WR of an SH -> memWE=0 at once, state IDLE, busy=0, word at that address unchanged.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// lsu_dmem_master: load/store unit driving a word-wide data-memory port.
// Loads return byte/half/word, sign- or zero-extended. Sub-word stores are
// done as read-modify-write because the memory only writes whole words.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses fault
// instead of being silently aligned).
module lsu_dmem_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic              isStore,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] storeData,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [DATA_W-1:0] loadData,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWE,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_e;

  state_e            state_q;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [DATA_W-1:0] sdata_q;
  logic              busy_q, done_q, fault_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, load_data_q;

  logic              legal_f3, is_h, is_w, req_fault;
  logic [1:0]        req_off;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [DATA_W-1:0] load_ext_d, merged_d;

  // Decode the incoming request: funct3 legality, fault and effective lane.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    legal_f3  = isStore ? (funct3 inside {3'b000, 3'b001, 3'b010})
                        : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    is_h      = (funct3[1:0] == 2'b01);
    is_w      = (funct3[1:0] == 2'b10);
    req_off   = addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    req_fault = !legal_f3 || (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
`else
    req_fault = !legal_f3;
    if (is_w)      req_off    = 2'b00;
    else if (is_h) req_off[0] = 1'b0;
`endif
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    rd_byte = memRData[7:0];
    case (lane_q)
      2'd1:    rd_byte = memRData[15:8];
      2'd2:    rd_byte = memRData[23:16];
      2'd3:    rd_byte = memRData[31:24];
      default: rd_byte = memRData[7:0];
    endcase
    rd_half = lane_q[1] ? memRData[31:16] : memRData[15:0];

    case (funct3_q[1:0])
      2'b00:   load_ext_d = {{(DATA_W-8){rd_byte[7] & ~funct3_q[2]}}, rd_byte};
      2'b01:   load_ext_d = {{(DATA_W-16){rd_half[15] & ~funct3_q[2]}}, rd_half};
      default: load_ext_d = memRData;
    endcase

    merged_d = memRData;
    if (funct3_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd1:    merged_d[15:8]  = sdata_q[7:0];
        2'd2:    merged_d[23:16] = sdata_q[7:0];
        2'd3:    merged_d[31:24] = sdata_q[7:0];
        default: merged_d[7:0]   = sdata_q[7:0];
      endcase
    end else if (funct3_q[1:0] == 2'b01) begin
      if (lane_q[1]) merged_d[31:16] = sdata_q[15:0];
      else           merged_d[15:0]  = sdata_q[15:0];
    end
  end

  // Control FSM with registered outputs; async reset aborts any access at once.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      sdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      load_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            is_store_q <= isStore;
            funct3_q   <= funct3;
            lane_q     <= req_off;
            sdata_q    <= storeData;
            mem_addr_q <= {addr[ADDR_W-1:2], 2'b00};
            if (req_fault) begin
              fault_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else if (isStore && is_w) begin
              mem_wdata_q <= storeData;
              mem_we_q    <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= S_WR;
            end else begin
              busy_q  <= 1'b1;
              state_q <= S_RD;
            end
          end
        end
        S_RD: begin
          if (is_store_q) begin
            mem_wdata_q <= merged_d;
            mem_we_q    <= 1'b1;
            state_q     <= S_WR;
          end else begin
            load_data_q <= load_ext_d;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_FIN;
          end
        end
        S_WR: begin
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_FIN;
        end
        S_FIN: begin
          done_q     <= 1'b0;
          fault_q    <= 1'b0;
          mem_addr_q <= '0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign fault    = fault_q;
  assign loadData = load_data_q;
  assign memAddr  = mem_addr_q;
  assign memWE    = mem_we_q;
  assign memWData = mem_wdata_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed self-checking bench for lsu_dmem_master with a word-wide memory model.
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, isStore;
  logic [2:0]  funct3;
  logic [31:0] addr, storeData;
  logic        busy, done, fault, memWE;
  logic [31:0] loadData, memAddr, memWData, memRData;

  logic [31:0] mem [64];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ld;

  lsu_dmem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .req(req), .isStore(isStore), .funct3(funct3),
    .addr(addr), .storeData(storeData), .busy(busy), .done(done), .fault(fault),
    .loadData(loadData), .memAddr(memAddr), .memWE(memWE), .memWData(memWData),
    .memRData(memRData)
  );

  always #5 clk = ~clk;

  assign memRData = mem[memAddr[7:2]];
  always @(posedge clk) if (memWE) mem[memAddr[7:2]] <= memWData;

  // Issue one request and watch it until done (bounded); results per cycle k after accept.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, output int lat, output int we_cnt,
                        output int we_cyc, output int busy_cnt, output logic [31:0] we_data,
                        output logic [31:0] op_addr, output logic flt, output logic [31:0] ld);
    lat = 0; we_cnt = 0; we_cyc = 0; busy_cnt = 0; we_data = 0; op_addr = 0; flt = 0; ld = 0;
    @(negedge clk);
    req = 1'b1; isStore = st; funct3 = f3; addr = a; storeData = sd;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) op_addr = memAddr;
      if (busy) busy_cnt++;
      if (memWE) begin we_cnt++; we_cyc = k; we_data = memWData; end
      if (done) begin lat = k; flt = fault; ld = loadData; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 1'b0; isStore = 1'b0; funct3 = 3'b000; addr = '0; storeData = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, fault, memWE} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 0000", {busy, done, fault, memWE});
    end
    n_cmp++;
    if ({memAddr, memWData, loadData} !== 96'd0) begin
      n_bad++; $display("FAIL reset_data got %h %h %h want zeros", memAddr, memWData, loadData);
    end
    rstn = 1'b1;
    exp_ld = 32'h0;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [7] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b100, 3'b000, 3'b100};
    logic [31:0] as  [7] = '{32'h12, 32'h12, 32'h12, 32'h10, 32'h10, 32'h13, 32'h11};
    logic [31:0] exs [7] = '{32'hFFFFFFFF, 32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01,
                             32'h00000001, 32'hFFFFFF80, 32'h0000007F};
    int lat, wc, wcy, bc; logic [31:0] wd, oa, ld; logic flt;
    mem[4] = 32'h80FF7F01;
    for (int i = 0; i < 7; i++) begin
      run_op(1'b0, f3s[i], as[i], 32'h0, lat, wc, wcy, bc, wd, oa, flt, ld);
      n_cmp++;
      if (ld !== exs[i]) begin n_bad++; $display("FAIL load%0d_data got %h want %h", i, ld, exs[i]); end
      n_cmp++;
      if (lat !== 2 || flt !== 1'b0) begin
        n_bad++; $display("FAIL load%0d_lat got lat=%0d fault=%b want 2 0", i, lat, flt);
      end
      n_cmp++;
      if (wc !== 0 || bc !== 1 || oa !== 32'h10) begin
        n_bad++; $display("FAIL load%0d_bus got we=%0d busy=%0d addr=%h want 0 1 10", i, wc, bc, oa);
      end
      exp_ld = exs[i];
    end
  endtask

  task automatic test_sub_store();
    int lat, wc, wcy, bc; logic [31:0] wd, oa, ld; logic flt;
    mem[4] = 32'h11223344;
    run_op(1'b1, 3'b000, 32'h11, 32'h000000AB, lat, wc, wcy, bc, wd, oa, flt, ld);
    n_cmp++;
    if (wc !== 1 || wcy !== 2 || wd !== 32'h1122AB44) begin
      n_bad++; $display("FAIL sb_write got n=%0d at=%0d data=%h want 1 2 1122ab44", wc, wcy, wd);
    end
    n_cmp++;
    if (lat !== 3 || flt !== 1'b0 || bc !== 2) begin
      n_bad++; $display("FAIL sb_lat got lat=%0d fault=%b busy=%0d want 3 0 2", lat, flt, bc);
    end
    n_cmp++;
    if (mem[4] !== 32'h1122AB44 || ld !== exp_ld) begin
      n_bad++; $display("FAIL sb_mem got mem=%h ld=%h want 1122ab44 %h", mem[4], ld, exp_ld);
    end
    mem[5] = 32'h55667788;
    run_op(1'b1, 3'b001, 32'h16, 32'h9999CAFE, lat, wc, wcy, bc, wd, oa, flt, ld);
    n_cmp++;
    if (wc !== 1 || wd !== 32'hCAFE7788 || lat !== 3 || oa !== 32'h14) begin
      n_bad++; $display("FAIL sh_store got n=%0d data=%h lat=%0d addr=%h want 1 cafe7788 3 14",
                        wc, wd, lat, oa);
    end
  endtask

  task automatic test_back_to_back();
    int we_n = 0, we_at = 0, done_at = 0, extra = 0;
    logic [31:0] oa = 0;
    @(negedge clk);
    req = 1'b1; isStore = 1'b1; funct3 = 3'b010; addr = 32'h20; storeData = 32'hDEADBEEF;
    @(negedge clk);
    isStore = 1'b0; addr = 32'h10;  // req kept high while busy: must be ignored
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) oa = memAddr;
      if (memWE) begin we_n++; we_at = k; end
      if (done) begin done_at = k; req = 1'b0; break; end
    end
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy || memWE) extra++;
    end
    n_cmp++;
    if (we_n !== 1 || we_at !== 1 || oa !== 32'h20) begin
      n_bad++; $display("FAIL sw_write got n=%0d at=%0d addr=%h want 1 1 20", we_n, we_at, oa);
    end
    n_cmp++;
    if (done_at !== 2 || mem[8] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL sw_done got done=%0d mem=%h want 2 deadbeef", done_at, mem[8]);
    end
    n_cmp++;
    if (extra !== 0) begin n_bad++; $display("FAIL busy_req_ignored got %0d activity want 0", extra); end
  endtask

  task automatic test_misalign();
    int lat, wc, wcy, bc; logic [31:0] wd, oa, ld; logic flt;
    run_op(1'b0, 3'b010, 32'h22, 32'h0, lat, wc, wcy, bc, wd, oa, flt, ld);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++;
    if (lat !== 1 || flt !== 1'b1 || wc !== 0 || ld !== exp_ld) begin
      n_bad++; $display("FAIL lw_misalign got lat=%0d fault=%b we=%0d ld=%h want 1 1 0 %h",
                        lat, flt, wc, ld, exp_ld);
    end
`else
    n_cmp++;
    if (lat !== 2 || flt !== 1'b0 || wc !== 0 || ld !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL lw_misalign got lat=%0d fault=%b we=%0d ld=%h want 2 0 0 deadbeef",
                        lat, flt, wc, ld);
    end
    exp_ld = 32'hDEADBEEF;
`endif
  endtask

  task automatic test_illegal();
    int lat, wc, wcy, bc; logic [31:0] wd, oa, ld; logic flt;
    run_op(1'b0, 3'b011, 32'h10, 32'h0, lat, wc, wcy, bc, wd, oa, flt, ld);
    n_cmp++;
    if (lat !== 1 || flt !== 1'b1 || bc !== 0 || ld !== exp_ld) begin
      n_bad++; $display("FAIL ld_illegal got lat=%0d fault=%b busy=%0d ld=%h want 1 1 0 %h",
                        lat, flt, bc, ld, exp_ld);
    end
    run_op(1'b1, 3'b100, 32'h20, 32'h12345678, lat, wc, wcy, bc, wd, oa, flt, ld);
    n_cmp++;
    if (lat !== 1 || flt !== 1'b1 || wc !== 0 || mem[8] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL st_illegal got lat=%0d fault=%b we=%0d mem=%h want 1 1 0 deadbeef",
                        lat, flt, wc, mem[8]);
    end
  endtask

  task automatic test_wrap();
    int lat, wc, wcy, bc; logic [31:0] wd, oa, ld; logic flt;
    mem[63] = 32'h0000C300;
    run_op(1'b0, 3'b100, 32'hFFFFFFFD, 32'h0, lat, wc, wcy, bc, wd, oa, flt, ld);
    n_cmp++;
    if (oa !== 32'hFFFFFFFC || ld !== 32'h000000C3 || lat !== 2) begin
      n_bad++; $display("FAIL addr_wrap got addr=%h ld=%h lat=%0d want fffffffc 000000c3 2", oa, ld, lat);
    end
    exp_ld = 32'h000000C3;
  endtask

  task automatic test_reset_mid_wr();
    int lat, wc, wcy, bc; logic [31:0] wd, oa, ld; logic flt;
    bit seen = 0;
    mem[6] = 32'hA5A5A5A5;
    @(negedge clk);
    req = 1'b1; isStore = 1'b1; funct3 = 3'b001; addr = 32'h18; storeData = 32'h00001234;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (memWE) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL sh_reach_wr got no memWE want WR state"); end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({memWE, busy, done, memAddr} !== 35'd0) begin
      n_bad++; $display("FAIL mid_reset got we=%b busy=%b done=%b addr=%h want 0 0 0 0",
                        memWE, busy, done, memAddr);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    n_cmp++;
    if (mem[6] !== 32'hA5A5A5A5) begin
      n_bad++; $display("FAIL mid_reset_mem got %h want a5a5a5a5", mem[6]);
    end
    run_op(1'b0, 3'b010, 32'h18, 32'h0, lat, wc, wcy, bc, wd, oa, flt, ld);
    n_cmp++;
    if (lat !== 2 || ld !== 32'hA5A5A5A5 || wc !== 0) begin
      n_bad++; $display("FAIL post_reset_lw got lat=%0d ld=%h we=%0d want 2 a5a5a5a5 0", lat, ld, wc);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_sub_store();
    test_back_to_back();
    test_misalign();
    test_illegal();
    test_wrap();
    test_reset_mid_wr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
